// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the MEM-stage request/response handshake and the data-memory
// controller bus of mem_access_unit.
//   req_*          : request from the pipeline (valid/ready handshake)
//   resp_*         : one-cycle completion pulse with load data and error flag
//   mem_*          : word-wide bus to the data-memory controller
// Modports:
//   slave  : the access unit (accepts requests, drives the memory bus)
//   master : the environment (pipeline + memory controller side)
// ---------------------------------------------------------------------------
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_write_data, mem_write,
    input  mem_read_data
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_write_data, mem_write,
    output mem_read_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Initiator side of the data-memory interface. Turns byte/half/word loads
// and stores into whole-word memory cycles: sub-word loads extract a lane
// and sign/zero extend it, sub-word stores do read-modify-write.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : mem_access_unit_if.slave (request/response + memory bus)
// Parameters:
//   ADDR_BITS  : byte-address bits backed by memory (bounds check only)
//   RESET_ADDR : mem_address value out of reset
// Optional feature macro: BOUNDS_CHECK_EN
//   Defined   -> requests with req_addr[31:ADDR_BITS] != 0 complete with
//                resp_error and no memory cycle.
//   Undefined -> upper address bits pass through; the controller aliases.
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned ADDR_BITS  = 10,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_e      state_q, state_d;

  // Latched request fields
  logic        write_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        signed_q;
  logic [15:0] wdata_q;

  // Registered outputs
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic        mem_write_q, mem_write_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        accept_s;
  logic        misaligned_s;
  logic        illegal_s;
  logic        oob_s;
  logic        req_err_s;
  logic        needs_read_s;

  // Little-endian lane extraction with optional sign extension.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      SZ_WORD: r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Overlay the low byte/half of the store data onto the addressed lane.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [15:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: r[{off, 3'b000} +: 8]        = wdata[7:0];
      SZ_HALF: r[{off[1], 4'b0000} +: 16]   = wdata[15:0];
      default: r = word;
    endcase
    return r;
  endfunction

  assign accept_s     = bus.req_valid && (state_q == S_IDLE);
  assign illegal_s    = (bus.req_size == SZ_ILL);
  assign misaligned_s = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                        ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`ifdef BOUNDS_CHECK_EN
  assign oob_s        = |bus.req_addr[31:ADDR_BITS];
`else
  assign oob_s        = 1'b0;
`endif
  assign req_err_s    = illegal_s || misaligned_s || oob_s;
  // Loads and sub-word stores both need the current memory word first.
  assign needs_read_s = !bus.req_write || (bus.req_size != SZ_WORD);

  // State register, latched request fields and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      write_q          <= 1'b0;
      size_q           <= SZ_BYTE;
      off_q            <= 2'b00;
      signed_q         <= 1'b0;
      wdata_q          <= 16'h0000;
      mem_address_q    <= RESET_ADDR;
      mem_write_data_q <= 32'h0000_0000;
      mem_write_q      <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_error_q     <= 1'b0;
      resp_rdata_q     <= 32'h0000_0000;
    end else begin
      state_q          <= state_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_write_q      <= mem_write_d;
      resp_valid_q     <= resp_valid_d;
      resp_error_q     <= resp_error_d;
      resp_rdata_q     <= resp_rdata_d;
      if (accept_s) begin
        write_q  <= bus.req_write;
        size_q   <= bus.req_size;
        off_q    <= bus.req_addr[1:0];
        signed_q <= bus.req_signed;
        wdata_q  <= bus.req_wdata[15:0];
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!accept_s) begin
          state_d = S_IDLE;
        end else if (req_err_s) begin
          state_d = S_RESP;
        end else if (needs_read_s) begin
          state_d = S_READ;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (write_q) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_RESP;
        end
      end
      S_WRITE:   state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; pulses follow the next state so
  // mem_write is high exactly in WRITE and resp_valid exactly in RESP.
  always_comb begin
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    resp_rdata_d     = 32'h0000_0000;
    resp_error_d     = 1'b0;
    resp_valid_d     = (state_d == S_RESP);
    mem_write_d      = (state_d == S_WRITE);
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          mem_address_d = {bus.req_addr[31:2], 2'b00};
          resp_error_d  = req_err_s;
          if (!req_err_s && !needs_read_s) begin
            mem_write_data_d = bus.req_wdata;
          end else begin
            mem_write_data_d = mem_write_data_q;
          end
        end else begin
          mem_address_d = mem_address_q;
        end
      end
      S_CAPTURE: begin
        if (write_q) begin
          mem_write_data_d = merge_lane(bus.mem_read_data, wdata_q, size_q, off_q);
        end else begin
          resp_rdata_d = extract_lane(bus.mem_read_data, size_q, off_q, signed_q);
        end
      end
      default: begin
        resp_rdata_d = 32'h0000_0000;
      end
    endcase
  end

  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_error     = resp_error_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;
  assign bus.mem_write      = mem_write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit with a 256x32 synchronous-read memory
// model. Stimulus pushes expected responses and memory writes into queues;
// a negedge monitor pops and compares whenever resp_valid or mem_write is
// seen, including latency measured from the accept edge.
// Honours BOUNDS_CHECK_EN for the out-of-range cases.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter: after N rising edges it reads N.
  always @(posedge clk) cyc <= cyc + 1;

  // Memory controller model: registered read, write on mem_write.
  logic [31:0] tmem [256] = '{default: 32'h0000_0000};
  always @(posedge clk) begin
    if (bus.mem_write) tmem[bus.mem_address[9:2]] <= bus.mem_write_data;
    bus.mem_read_data <= tmem[bus.mem_address[9:2]];
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compare every response and every memory write to expectations.
  always @(negedge clk) begin
    resp_t e;
    wr_t   w;
    if (bus.resp_valid) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp: got resp_valid expected none (cycle %0d)", cyc);
      end else begin
        e = rq.pop_front();
        chk("resp_error", {31'd0, bus.resp_error}, {31'd0, e.err});
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_latency", cyc - e.acc, e.lat);
      end
    end
    if (bus.mem_write) begin
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got write 0x%08h to 0x%08h expected none",
                 bus.mem_write_data, bus.mem_address);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", bus.mem_address, w.addr);
        chk("wr_data", bus.mem_write_data, w.data);
        chk("wr_cycle", cyc, w.due);
      end
    end
  end

  // Issue one request at a negedge once the unit is ready; queue expectations.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat,
                       input logic exp_w, input int w_lat, input logic [31:0] w_data);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: got req_ready 0 expected 1");
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    rq.push_back('{exp_err, exp_rdata, exp_lat, cyc});
    if (exp_w) wq.push_back('{{addr[31:2], 2'b00}, w_data, cyc + w_lat});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    $display("reset state check: %s", tag);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_error", {31'd0, bus.resp_error}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0000_0000);
    chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("rst_mem_wdata", bus.mem_write_data, 32'h0000_0000);
    chk("rst_mem_address", bus.mem_address, 32'h0000_0000);
  endtask

  initial begin
    int n;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_state("power-up");

    // wr sz sg addr wdata | err rdata lat | wr wlat wdata
    issue(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0,        2, 1'b1, 1, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h010, 32'h0,        1'b0, 32'hDEADBEEF, 3, 1'b0, 0, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h020, 32'h11223344, 1'b0, 32'h0,        2, 1'b1, 1, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 32'h022, 32'h123456AA, 1'b0, 32'h0,        4, 1'b1, 3, 32'h11AA3344);
    issue(1'b0, 2'b00, 1'b1, 32'h022, 32'h0,        1'b0, 32'hFFFFFFAA, 3, 1'b0, 0, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h030, 32'h80FF7F01, 1'b0, 32'h0,        2, 1'b1, 1, 32'h80FF7F01);
    issue(1'b0, 2'b00, 1'b1, 32'h032, 32'h0,        1'b0, 32'hFFFFFFFF, 3, 1'b0, 0, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h033, 32'h0,        1'b0, 32'h00000080, 3, 1'b0, 0, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h033, 32'h0,        1'b0, 32'hFFFFFF80, 3, 1'b0, 0, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h030, 32'h0,        1'b0, 32'h00007F01, 3, 1'b0, 0, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h032, 32'h0,        1'b0, 32'hFFFF80FF, 3, 1'b0, 0, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h032, 32'h0,        1'b0, 32'h000080FF, 3, 1'b0, 0, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h012, 32'h1234BEEF, 1'b0, 32'h0,        4, 1'b1, 3, 32'hBEEFBEEF);
    issue(1'b0, 2'b01, 1'b1, 32'h012, 32'h0,        1'b0, 32'hFFFFBEEF, 3, 1'b0, 0, 32'h0);
    // Errors: misaligned half load, misaligned word store, illegal size.
    issue(1'b0, 2'b01, 1'b0, 32'h041, 32'h0,        1'b1, 32'h0,        1, 1'b0, 0, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h042, 32'hCAFEF00D, 1'b1, 32'h0,        1, 1'b0, 0, 32'h0);
    issue(1'b1, 2'b11, 1'b0, 32'h040, 32'hCAFEF00D, 1'b1, 32'h0,        1, 1'b0, 0, 32'h0);
`ifdef BOUNDS_CHECK_EN
    issue(1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678, 1'b1, 32'h0,        1, 1'b0, 0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0,        1'b1, 32'h0,        1, 1'b0, 0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h000, 32'h0,        1'b0, 32'h00000000, 3, 1'b0, 0, 32'h0);
`else
    issue(1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678, 1'b0, 32'h0,        2, 1'b1, 1, 32'h12345678);
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0,        1'b0, 32'h12345678, 3, 1'b0, 0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h000, 32'h0,        1'b0, 32'h12345678, 3, 1'b0, 0, 32'h0);
`endif

    // Byte store abandoned by reset during its CAPTURE cycle.
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_abort", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h021;
    bus.req_wdata = 32'h00000055;
    @(posedge clk);            // accept -> READ
    #1 bus.req_valid = 1'b0;
    @(posedge clk);            // -> CAPTURE
    #1 reset = 1'b1;
    @(posedge clk);            // reset edge
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_state("after abort");

    // Reset and req_valid together: reset wins, nothing is accepted.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h020;
    bus.req_wdata = 32'hBAD0BAD0;
    reset = 1'b1;
    @(posedge clk);
    #1 begin
      bus.req_valid = 1'b0;
      reset = 1'b0;
    end
    @(negedge clk);
    chk("ready_after_sim_reset", {31'd0, bus.req_ready}, 32'd1);

    // Memory word must be untouched by both aborted stores.
    issue(1'b0, 2'b10, 1'b0, 32'h020, 32'h0,        1'b0, 32'h11AA3344, 3, 1'b0, 0, 32'h0);

    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("resp_queue_empty", rq.size(), 32'd0);
    chk("write_queue_empty", wq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
